// File: rtl/rv32_control_unit_if.sv
// rv32_control_unit_if: instruction in, decoded datapath controls and illegal-instruction flag out.
interface rv32_control_unit_if;
   logic [31:0] inst;
   logic        b_beq;
   logic        b_jal;
   logic        b_jalr;
   logic        reg_write;
   logic        mem_to_reg;
   logic        mem_write;
   logic [3:0]  alu_control;
   logic        alu_src;
   logic [2:0]  imm_control;
   logic        illegal_inst;

   modport master (
      output inst,
      input  b_beq, b_jal, b_jalr, reg_write, mem_to_reg, mem_write,
      input  alu_control, alu_src, imm_control, illegal_inst
   );

   modport slave (
      input  inst,
      output b_beq, b_jal, b_jalr, reg_write, mem_to_reg, mem_write,
      output alu_control, alu_src, imm_control, illegal_inst
   );
endinterface

// File: rtl/rv32_control_unit.sv
// rv32_control_unit: combinational RV32I(+M) main decoder with a sticky illegal-instruction flag.
// Define CTRL_MULDIV_EN to decode MUL/DIV/REM; otherwise funct7=0000001 R-type words are illegal.
module rv32_control_unit (
   input  logic               clk,
   input  logic               reset,
   rv32_control_unit_if.slave bus
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SLL   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_SLT   = 4'b1000;
   localparam logic [3:0] ALU_SLTU  = 4'b1001;
`ifdef CTRL_MULDIV_EN
   localparam logic [3:0] ALU_MUL   = 4'b1010;
   localparam logic [3:0] ALU_DIV   = 4'b1011;
   localparam logic [3:0] ALU_REM   = 4'b1100;
`endif
   localparam logic [3:0] ALU_PASSB = 4'b1101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       beq, jal, jalr, rw, m2r, mw, src, bad;
   logic [3:0] alu;
   logic [2:0] imm;
   logic       unused_fields;

   assign opcode        = bus.inst[6:0];
   assign funct3        = bus.inst[14:12];
   assign funct7        = bus.inst[31:25];
   assign unused_fields = ^{bus.inst[24:15], bus.inst[11:7]};

   // funct3 -> ALU op shared by R-type (funct7=0) and I-ALU
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

   always_comb begin
      beq  = 1'b0;
      jal  = 1'b0;
      jalr = 1'b0;
      rw   = 1'b0;
      m2r  = 1'b0;
      mw   = 1'b0;
      src  = 1'b0;
      alu  = ALU_ADD;
      imm  = IMM_I;
      bad  = 1'b0;
      case (opcode)
         OP_R: begin
            rw = 1'b1;
            case (funct7)
               7'b0000000: alu = base_op(funct3);
               7'b0100000: begin
                  alu = funct3 == 3'b000 ? ALU_SUB : ALU_SRA;
                  bad = funct3 != 3'b000 && funct3 != 3'b101;
               end
`ifdef CTRL_MULDIV_EN
               7'b0000001: begin
                  alu = funct3 == 3'b000 ? ALU_MUL : funct3 == 3'b100 ? ALU_DIV : ALU_REM;
                  bad = funct3 != 3'b000 && funct3 != 3'b100 && funct3 != 3'b110;
               end
`endif
               default: bad = 1'b1;
            endcase
         end
         OP_I: begin
            rw  = 1'b1;
            src = 1'b1;
            alu = base_op(funct3);
            if (funct3 == 3'b001)
               bad = funct7 != 7'b0000000;
            else if (funct3 == 3'b101) begin
               alu = funct7 == 7'b0100000 ? ALU_SRA : ALU_SRL;
               bad = funct7 != 7'b0000000 && funct7 != 7'b0100000;
            end
         end
         OP_LOAD: begin
            rw  = 1'b1;
            m2r = 1'b1;
            src = 1'b1;
            bad = funct3 != 3'b010;
         end
         OP_STORE: begin
            mw  = 1'b1;
            src = 1'b1;
            imm = IMM_S;
            bad = funct3 != 3'b010;
         end
         OP_BRANCH: begin
            beq = 1'b1;
            alu = ALU_SUB;
            imm = IMM_B;
            bad = funct3 != 3'b000;
         end
         OP_JAL: begin
            jal = 1'b1;
            rw  = 1'b1;
            imm = IMM_J;
         end
         OP_JALR: begin
            jalr = 1'b1;
            rw   = 1'b1;
            src  = 1'b1;
            bad  = funct3 != 3'b000;
         end
         OP_LUI: begin
            rw  = 1'b1;
            src = 1'b1;
            alu = ALU_PASSB;
            imm = IMM_U;
         end
         default: bad = 1'b1;
      endcase
      // an illegal word must leave no enable asserted
      if (bad) begin
         beq  = 1'b0;
         jal  = 1'b0;
         jalr = 1'b0;
         rw   = 1'b0;
         m2r  = 1'b0;
         mw   = 1'b0;
         src  = 1'b0;
         alu  = ALU_ADD;
         imm  = IMM_I;
      end
   end

   assign bus.b_beq       = beq;
   assign bus.b_jal       = jal;
   assign bus.b_jalr      = jalr;
   assign bus.reg_write   = rw;
   assign bus.mem_to_reg  = m2r;
   assign bus.mem_write   = mw;
   assign bus.alu_src     = src;
   assign bus.alu_control = alu;
   assign bus.imm_control = imm;

   always_ff @(posedge clk or posedge reset)
      if (reset)
         bus.illegal_inst <= 1'b0;
      else if (bad)
         bus.illegal_inst <= 1'b1;
endmodule

// File: tb/tb_rv32_control_unit.sv
// tb_rv32_control_unit: randomized decode against a mask/match rule table, checked through a scoreboard queue.
module tb_rv32_control_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic sticky = 1'b0;

   rv32_control_unit_if bus();
   rv32_control_unit dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [13:0] ctl;
      logic        flag;
   } exp_t;
   exp_t q[$];

   logic [31:0] r_mask[$];
   logic [31:0] r_match[$];
   logic [13:0] r_ctl[$];

   localparam logic [6:0] BEQ = 7'b1000000, JAL = 7'b0100000, JALR = 7'b0010000,
                          RW = 7'b0001000, M2R = 7'b0000100, MW = 7'b0000010, SRC = 7'b0000001;

   function automatic logic [13:0] mk(input logic [6:0] en, input logic [3:0] alu, input logic [2:0] imm);
      return {en, alu, imm};
   endfunction

   task automatic add(input logic [31:0] m, input logic [31:0] v, input logic [13:0] c);
      r_mask.push_back(m);
      r_match.push_back(v);
      r_ctl.push_back(c);
   endtask

   // a word is legal iff some rule matches; illegal words expect all-zero controls
   task automatic model(input logic [31:0] i, output logic [13:0] c, output logic ok);
      c  = '0;
      ok = 1'b0;
      foreach (r_mask[k])
         if ((i & r_mask[k]) == r_match[k]) begin
            c  = r_ctl[k];
            ok = 1'b1;
         end
   endtask

   task automatic build_rules;
      int r0[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
      int ia[8] = '{0, -1, 8, 9, 4, -1, 3, 2};
      for (int f = 0; f < 8; f++) begin
         add(32'hFE00707F, 32'h33 | (32'(f) << 12), mk(RW, 4'(r0[f]), 3'd0));
         if (ia[f] >= 0) add(32'h0000707F, 32'h13 | (32'(f) << 12), mk(RW | SRC, 4'(ia[f]), 3'd0));
      end
      add(32'hFE00707F, 32'h40000033, mk(RW, 4'd1, 3'd0));
      add(32'hFE00707F, 32'h40005033, mk(RW, 4'd7, 3'd0));
`ifdef CTRL_MULDIV_EN
      add(32'hFE00707F, 32'h02000033, mk(RW, 4'd10, 3'd0));
      add(32'hFE00707F, 32'h02004033, mk(RW, 4'd11, 3'd0));
      add(32'hFE00707F, 32'h02006033, mk(RW, 4'd12, 3'd0));
`endif
      add(32'hFE00707F, 32'h00001013, mk(RW | SRC, 4'd5, 3'd0));
      add(32'hFE00707F, 32'h00005013, mk(RW | SRC, 4'd6, 3'd0));
      add(32'hFE00707F, 32'h40005013, mk(RW | SRC, 4'd7, 3'd0));
      add(32'h0000707F, 32'h00002003, mk(RW | M2R | SRC, 4'd0, 3'd0));
      add(32'h0000707F, 32'h00002023, mk(MW | SRC, 4'd0, 3'd1));
      add(32'h0000707F, 32'h00000063, mk(BEQ, 4'd1, 3'd2));
      add(32'h0000007F, 32'h0000006F, mk(JAL | RW, 4'd0, 3'd4));
      add(32'h0000707F, 32'h00000067, mk(JALR | RW | SRC, 4'd0, 3'd0));
      add(32'h0000007F, 32'h00000037, mk(RW | SRC, 4'd13, 3'd3));
   endtask

   // flag seen at the following negedge reflects only words captured at earlier edges
   task automatic issue(input logic [31:0] i, input logic rst_val);
      exp_t e;
      logic ok;
      @(posedge clk);
      #1;
      reset = rst_val;
      bus.inst = i;
      if (rst_val) sticky = 1'b0;
      model(i, e.ctl, ok);
      e.inst = i;
      e.flag = sticky;
      q.push_back(e);
      if (!rst_val && !ok) sticky = 1'b1;
   endtask

   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         logic [13:0] got;
         e = q.pop_front();
         got = {bus.b_beq, bus.b_jal, bus.b_jalr, bus.reg_write, bus.mem_to_reg, bus.mem_write,
                bus.alu_src, bus.alu_control, bus.imm_control};
         total++;
         if (got !== e.ctl) begin
            bad++;
            $display("FAIL ctl inst=%08h got=%014b exp=%014b", e.inst, got, e.ctl);
         end
         total++;
         if (bus.illegal_inst !== e.flag) begin
            bad++;
            $display("FAIL flag inst=%08h got=%b exp=%b", e.inst, bus.illegal_inst, e.flag);
         end
      end

   initial begin
      logic [31:0] dir[$] = '{32'h00000033, 32'h00007033, 32'h40000033, 32'h00002033, 32'h00001033,
                              32'h00005033, 32'h40005033, 32'h02004033, 32'h02006033, 32'h00000033,
                              32'h00000013, 32'h00002003, 32'h00002023, 32'h00000063, 32'h0000006F,
                              32'h00000067, 32'hFFFFFFFF, 32'h00000033, 32'h00000033};
      logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h00};
      logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
      bus.inst = 32'h0;
      build_rules();
      issue(32'hFFFFFFFF, 1'b1);
      issue(32'hFFFFFFFF, 1'b1);
      issue(32'h00000033, 1'b0);
      issue(32'h02004033, 1'b0);
      issue(32'h00000033, 1'b0);
      issue(32'h00000033, 1'b1);
      foreach (dir[k]) issue(dir[k], 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (bus.illegal_inst !== 1'b0) begin
         bad++;
         $display("FAIL rst_clear got=%b exp=0", bus.illegal_inst);
      end
      sticky = 1'b0;
      for (int n = 0; n < 600; n++) begin
         logic [31:0] w;
         w = $urandom;
         w[6:0] = $urandom_range(0, 8) == 8 ? 7'($urandom) : ops[$urandom_range(0, 7)];
         f7s[3] = 7'($urandom);
         w[31:25] = f7s[$urandom_range(0, 3)];
         issue(w, $urandom_range(0, 39) == 0);
      end
      for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
